// File: rtl/oc7to3_input.sv
// oc7to3_input: seven-input ones counter, full-adder tree with a registered 3-bit count
module oc7to3_fa (
    input  logic x,
    input  logic y,
    input  logic z,
    output logic s,
    output logic co
);
    assign s  = x ^ y ^ z;
    assign co = (x & y) | (x & z) | (y & z);
endmodule

module oc7to3_input (
    input  logic clk,
    input  logic rst,
    input  logic a,
    input  logic b,
    input  logic c,
    input  logic d,
    input  logic e,
    input  logic f,
    input  logic g,
    output logic w2,
    output logic w1,
    output logic w0
);
    logic s1, c1, s2, c2, sum0, c3, sum1, sum2;
    oc7to3_fa fa1 (.x(a),  .y(b),  .z(c), .s(s1),   .co(c1));
    oc7to3_fa fa2 (.x(d),  .y(e),  .z(f), .s(s2),   .co(c2));
    oc7to3_fa fa3 (.x(s1), .y(s2), .z(g), .s(sum0), .co(c3));
    // weight-2 carries from the first two levels combine into bits 1 and 2
    oc7to3_fa fa4 (.x(c1), .y(c2), .z(c3), .s(sum1), .co(sum2));
    always_ff @(posedge clk or posedge rst)
        if (rst) {w2, w1, w0} <= 3'd0;
        else     {w2, w1, w0} <= {sum2, sum1, sum0};
endmodule

// File: tb/tb_oc7to3_input.sv
// tb_oc7to3_input: random and directed checks of the registered popcount against a reference model
module tb_oc7to3_input;
    logic clk = 0, rst = 1;
    logic [6:0] in = '0;
    logic a, b, c, d, e, f, g, w2, w1, w0;
    int checks = 0, failures = 0;
    assign {a, b, c, d, e, f, g} = in;
    wire [2:0] cnt = {w2, w1, w0};

    oc7to3_input dut (.clk(clk), .rst(rst), .a(a), .b(b), .c(c), .d(d), .e(e),
                      .f(f), .g(g), .w2(w2), .w1(w1), .w0(w0));

    always #5 clk = ~clk;

    function automatic logic [2:0] popcnt(input logic [6:0] v);
        int n = 0;
        for (int i = 0; i < 7; i++) n += int'(v[i]);
        return 3'(n);
    endfunction

    task automatic check(input string tag, input logic [2:0] got, input logic [2:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%b expected=%b at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step(input string tag, input logic [6:0] v);
        @(negedge clk);
        in = v;
        @(posedge clk);
        #1 check(tag, cnt, popcnt(v));
    endtask

    logic [6:0] walk [11] = '{7'b0000000, 7'b1000000, 7'b1100000, 7'b0100000,
                              7'b0110000, 7'b0111000, 7'b0111100, 7'b1111100,
                              7'b1111110, 7'b1111010, 7'b1111011};
    logic [2:0] walk_exp [11] = '{3'd0, 3'd1, 3'd2, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5,
                                  3'd6, 3'd5, 3'd6};

    initial begin
        in = 7'h7f;
        #2 check("reset_async", cnt, 3'd0);
        @(posedge clk);
        #1 check("reset_hold_edge", cnt, 3'd0);
        @(negedge clk);
        rst = 0;
        @(posedge clk);
        #1 check("reset_release", cnt, 3'd7);

        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            in = walk[i];
            @(posedge clk);
            #1 check("walk", cnt, walk_exp[i]);
        end

        for (int v = 0; v < 128; v++) step("exhaustive", 7'(v));

        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            in = 7'd1 << i;
            @(posedge clk);
            #1 check("single", cnt, 3'd1);
        end
        for (int i = 0; i < 7; i++)
            for (int j = i + 1; j < 7; j++) begin
                @(negedge clk);
                in = (7'd1 << i) | (7'd1 << j);
                @(posedge clk);
                #1 check("pair", cnt, 3'd2);
            end

        step("mid_pre", 7'b1110000);
        #2 rst = 1;
        #1 check("mid_async", cnt, 3'd0);
        #1 rst = 0;
        #1 check("mid_released_no_edge", cnt, 3'd0);
        @(posedge clk);
        #1 check("mid_after", cnt, 3'd3);

        step("hold_pre", 7'b0000001);
        @(negedge clk);
        in = 7'b1111111;
        #2 check("hold_between", cnt, 3'd1);
        in = 7'b0110110;
        @(posedge clk);
        #1 check("hold_after", cnt, 3'd4);

        for (int k = 0; k < 300; k++) step("random", 7'($urandom));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
